retire_trace_monitor: RTL and testbench

- Synthesizable retirement-trace collector for the MIPS cores: captures up to LANES committed instructions per cycle into an in-order FIFO.
- A downstream consumer drains the FIFO over a valid/ready handshake. The consumer is the DPI reference-model checker or an on-chip scoreboard.
- Keeps a shadow copy of $v0 (r2) and flags end-of-test when a SYSCALL retires with $v0 equal to the exit code.
- Supports single-issue (LANES=1) and dual-issue (LANES=2) cores and applies back-pressure so no retirement record is lost.

---
 rtl/retire_trace_monitor.sv | 118 +++++++++++
 tb/tb_retire_trace_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_monitor.sv
// Retirement-trace collector: packs up to LANES committed instructions per cycle
// into an in-order show-ahead FIFO and detects the SYSCALL exit via a shadow $v0.
module retire_trace_monitor #(
   parameter int          LANES         = 1,
   parameter int          DEPTH         = 8,
   parameter logic [31:0] SYSCALL_INSTR = 32'h0000000c,
   parameter logic [31:0] EXIT_CODE     = 32'h0000000a
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [LANES-1:0]            commit_valid,
   input  logic [LANES-1:0][31:0]      commit_pc,
   input  logic [LANES-1:0][31:0]      commit_instr,
   input  logic [LANES-1:0]            commit_we,
   input  logic [LANES-1:0][4:0]       commit_rd,
   input  logic [LANES-1:0][31:0]      commit_wdata,
   output logic                        stall_req,
   output logic                        trace_valid,
   input  logic                        trace_ready,
   output logic [31:0]                 trace_pc,
   output logic [31:0]                 trace_instr,
   output logic [31:0]                 trace_wdata,
   output logic                        trace_we,
   output logic [4:0]                  trace_rd,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        done,
   output logic                        overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } rec_t;

   rec_t              mem [DEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic [31:0]       shadow_v0;
   logic              pop;
   rec_t              head;

   logic [LANES-1:0]          wr_en;
   logic [LANES-1:0][AW-1:0]  wr_idx;
   logic [31:0]               v0_nxt;
   logic                      exit_hit, drop, stop;
   int                        n_enq, free;

   assign trace_valid = (count != '0);
   assign pop         = trace_valid && trace_ready;
   assign stall_req   = done || ((DEPTH - int'(count)) < LANES);

   assign head        = mem[rptr];
   assign trace_pc    = trace_valid ? head.pc    : '0;
   assign trace_instr = trace_valid ? head.instr : '0;
   assign trace_we    = trace_valid ? head.we    : 1'b0;
   assign trace_rd    = trace_valid ? head.rd    : '0;
   assign trace_wdata = trace_valid ? head.wdata : '0;

   // Walk lanes oldest-first: each lane sees $v0 as left by the older lanes,
   // takes the next free slot if one exists, and an exit cuts off younger lanes.
   always_comb begin
      v0_nxt   = shadow_v0;
      exit_hit = 1'b0;
      drop     = 1'b0;
      stop     = 1'b0;
      n_enq    = 0;
      free     = DEPTH - int'(count) + int'(pop);
      wr_en    = '0;
      wr_idx   = '0;
      for (int i = 0; i < LANES; i++) begin
         if (commit_valid[i] && !done && !stop) begin
            if (commit_instr[i] == SYSCALL_INSTR && v0_nxt == EXIT_CODE) begin
               exit_hit = 1'b1;
               stop     = 1'b1;
            end
            if (n_enq < free) begin
               wr_en[i]  = 1'b1;
               wr_idx[i] = wptr + AW'(n_enq);
               n_enq     = n_enq + 1;
            end else begin
               drop = 1'b1;
            end
            if (commit_we[i] && commit_rd[i] == 5'd2)
               v0_nxt = commit_wdata[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++)
         if (wr_en[i])
            mem[wr_idx[i]] <= rec_t'{pc: commit_pc[i], instr: commit_instr[i],
                                     we: commit_we[i], rd: commit_rd[i],
                                     wdata: commit_wdata[i]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         shadow_v0 <= '0;
      end else begin
         wptr      <= wptr + AW'(n_enq);
         rptr      <= rptr + AW'(int'(pop));
         count     <= CW'(int'(count) + n_enq - int'(pop));
         done      <= done | exit_hit;
         overflow  <= overflow | drop;
         shadow_v0 <= v0_nxt;
      end
   end
endmodule

// File: tb/tb_retire_trace_monitor.sv
// Directed bench: single- and dual-issue instances with per-instance expected-record queues.
module tb_retire_trace_monitor;
   localparam logic [31:0] SYS = 32'h0000000c;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } rec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [0:0]       v1, we1;
   logic [0:0][31:0] pc1, in1, wd1;
   logic [0:0][4:0]  rd1;
   logic             rdy1, st1, tv1, twe1, dn1, of1;
   logic [31:0]      tpc1, tin1, twd1;
   logic [4:0]       trd1;
   logic [3:0]       cnt1;

   logic [1:0]       v2, we2;
   logic [1:0][31:0] pc2, in2, wd2;
   logic [1:0][4:0]  rd2;
   logic             rdy2, st2, tv2, twe2, dn2, of2;
   logic [31:0]      tpc2, tin2, twd2;
   logic [4:0]       trd2;
   logic [3:0]       cnt2;

   retire_trace_monitor #(.LANES(1), .DEPTH(8)) u1 (
      .clk(clk), .reset(reset), .commit_valid(v1), .commit_pc(pc1), .commit_instr(in1),
      .commit_we(we1), .commit_rd(rd1), .commit_wdata(wd1), .stall_req(st1),
      .trace_valid(tv1), .trace_ready(rdy1), .trace_pc(tpc1), .trace_instr(tin1),
      .trace_wdata(twd1), .trace_we(twe1), .trace_rd(trd1), .count(cnt1),
      .done(dn1), .overflow(of1));

   retire_trace_monitor #(.LANES(2), .DEPTH(8)) u2 (
      .clk(clk), .reset(reset), .commit_valid(v2), .commit_pc(pc2), .commit_instr(in2),
      .commit_we(we2), .commit_rd(rd2), .commit_wdata(wd2), .stall_req(st2),
      .trace_valid(tv2), .trace_ready(rdy2), .trace_pc(tpc2), .trace_instr(tin2),
      .trace_wdata(twd2), .trace_we(twe2), .trace_rd(trd2), .count(cnt2),
      .done(dn2), .overflow(of2));

   rec_t q1[$];
   rec_t q2[$];
   int npass = 0;
   int ntot  = 0;
   int nfail = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      v1 = '0; we1 = '0; pc1 = '0; in1 = '0; wd1 = '0; rd1 = '0;
      v2 = '0; we2 = '0; pc2 = '0; in2 = '0; wd2 = '0; rd2 = '0;
   endtask

   task automatic c1(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic we, input logic [4:0] rd, input logic [31:0] wd,
                     input logic exp);
      v1[0] = v; pc1[0] = pc; in1[0] = ins; we1[0] = we; rd1[0] = rd; wd1[0] = wd;
      if (exp) q1.push_back(rec_t'{pc: pc, instr: ins, we: we, rd: rd, wdata: wd});
   endtask

   task automatic c2(input int l, input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic we, input logic [4:0] rd, input logic [31:0] wd,
                     input logic exp);
      v2[l] = v; pc2[l] = pc; in2[l] = ins; we2[l] = we; rd2[l] = rd; wd2[l] = wd;
      if (exp) q2.push_back(rec_t'{pc: pc, instr: ins, we: we, rd: rd, wdata: wd});
   endtask

   // Compare the head about to pop, then advance one edge; outputs sampled #1 after it.
   task automatic tick();
      if (tv1 && rdy1) begin
         if (q1.size() == 0) chk("u1_unexpected_pop", 128'(tv1), 128'(0));
         else chk("u1_head", 128'({tpc1, tin1, twe1, trd1, twd1}), 128'(q1.pop_front()));
      end
      if (tv2 && rdy2) begin
         if (q2.size() == 0) chk("u2_unexpected_pop", 128'(tv2), 128'(0));
         else chk("u2_head", 128'({tpc2, tin2, twe2, trd2, twd2}), 128'(q2.pop_front()));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      #2 reset = 1'b0;
      #1;
      chk({tag, "_cnt1"}, 128'(cnt1), 128'(0));
      chk({tag, "_tv1"},  128'(tv1),  128'(0));
      chk({tag, "_dn1"},  128'(dn1),  128'(0));
      chk({tag, "_of1"},  128'(of1),  128'(0));
      chk({tag, "_cnt2"}, 128'(cnt2), 128'(0));
      chk({tag, "_dn2"},  128'(dn2),  128'(0));
      chk({tag, "_of2"},  128'(of2),  128'(0));
      q1.delete();
      q2.delete();
      idle();
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rdy1 = 1'b0;
      rdy2 = 1'b0;
      #1 reset = 1'b0;
      #2;
      chk("rst_cnt1", 128'(cnt1), 128'(0));
      chk("rst_tv1",  128'(tv1),  128'(0));
      chk("rst_st1",  128'(st1),  128'(0));
      chk("rst_dn1",  128'(dn1),  128'(0));
      chk("rst_of1",  128'(of1),  128'(0));
      chk("rst_tpc1", 128'(tpc1), 128'(0));
      chk("rst_st2",  128'(st2),  128'(0));
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;

      // single-issue stream, 1-cycle latency
      rdy1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         c1(1'b1, 32'(i * 4), 32'h24080000 | 32'(i), 1'b1, 5'd8, 32'(i), 1'b1);
         tick();
         chk("s1_cnt", 128'(cnt1), 128'(1));
         chk("s1_tv",  128'(tv1),  128'(1));
      end
      idle();
      tick();
      chk("s1_empty", 128'(cnt1), 128'(0));

      // back-pressure and forced overflow
      rdy1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         c1(1'b1, 32'h100 + 32'(i * 4), 32'h24090000 | 32'(i), 1'b1, 5'd9, 32'(100 + i), 1'b1);
         tick();
         if (i == 6) chk("bp_st_at7", 128'(st1), 128'(0));
      end
      chk("bp_cnt", 128'(cnt1), 128'(8));
      chk("bp_st",  128'(st1),  128'(1));
      chk("bp_of0", 128'(of1),  128'(0));
      c1(1'b1, 32'h200, 32'h240a0001, 1'b1, 5'd10, 32'h1, 1'b0);
      tick();
      chk("ovf_set", 128'(of1),  128'(1));
      chk("ovf_cnt", 128'(cnt1), 128'(8));

      // drain
      idle();
      rdy1 = 1'b1;
      tick();
      chk("dr_st", 128'(st1),  128'(0));
      chk("dr_c7", 128'(cnt1), 128'(7));
      repeat (7) tick();
      chk("dr_cnt", 128'(cnt1), 128'(0));
      chk("dr_tv",  128'(tv1),  128'(0));
      chk("dr_twd", 128'(twd1), 128'(0));

      // exit detection on single issue
      c1(1'b1, 32'h300, SYS, 1'b0, 5'd0, 32'h0, 1'b1);
      tick();
      chk("sys_noexit", 128'(dn1), 128'(0));
      c1(1'b1, 32'h304, 32'h2400000a, 1'b1, 5'd0, 32'ha, 1'b1);
      tick();
      c1(1'b1, 32'h308, SYS, 1'b0, 5'd0, 32'h0, 1'b1);
      tick();
      chk("r0_noexit", 128'(dn1), 128'(0));
      c1(1'b1, 32'h30c, 32'h2402000a, 1'b1, 5'd2, 32'ha, 1'b1);
      tick();
      c1(1'b1, 32'h310, SYS, 1'b0, 5'd0, 32'h0, 1'b1);
      tick();
      chk("exit_done", 128'(dn1), 128'(1));
      chk("exit_st",   128'(st1), 128'(1));
      c1(1'b1, 32'h314, 32'h24030001, 1'b1, 5'd3, 32'h1, 1'b0);
      tick();
      idle();
      repeat (3) tick();
      chk("exit_cnt",    128'(cnt1),      128'(0));
      chk("exit_sticky", 128'(dn1),       128'(1));
      chk("ovf_sticky",  128'(of1),       128'(1));
      chk("exit_q1",     128'(q1.size()), 128'(0));

      do_reset("r1");

      // dual issue: lane order of the shadow, packing, younger discard
      rdy1 = 1'b0;
      rdy2 = 1'b1;
      c2(0, 1'b1, 32'h400, SYS, 1'b0, 5'd0, 32'h0, 1'b1);
      c2(1, 1'b1, 32'h404, 32'h2402000a, 1'b1, 5'd2, 32'ha, 1'b1);
      tick();
      chk("swap_done", 128'(dn2),  128'(0));
      chk("swap_cnt",  128'(cnt2), 128'(2));
      c2(0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      c2(1, 1'b1, 32'h408, 32'h24050005, 1'b1, 5'd5, 32'h5, 1'b1);
      tick();
      chk("pack_cnt", 128'(cnt2), 128'(2));
      c2(0, 1'b1, 32'h40c, 32'h2402000b, 1'b1, 5'd2, 32'hb, 1'b1);
      c2(1, 1'b1, 32'h410, SYS, 1'b0, 5'd0, 32'h0, 1'b1);
      tick();
      chk("v0b_done", 128'(dn2), 128'(0));
      c2(0, 1'b1, 32'h414, 32'h2402000a, 1'b1, 5'd2, 32'ha, 1'b1);
      c2(1, 1'b1, 32'h418, 32'h24060006, 1'b1, 5'd6, 32'h6, 1'b1);
      tick();
      c2(0, 1'b1, 32'h41c, SYS, 1'b0, 5'd0, 32'h0, 1'b1);
      c2(1, 1'b1, 32'h420, 32'h24070007, 1'b1, 5'd7, 32'h7, 1'b0);
      tick();
      chk("disc_done", 128'(dn2), 128'(1));
      chk("disc_of",   128'(of2), 128'(0));
      idle();
      repeat (8) tick();
      chk("disc_cnt", 128'(cnt2),      128'(0));
      chk("disc_st",  128'(st2),       128'(1));
      chk("disc_q2",  128'(q2.size()), 128'(0));

      do_reset("r2");

      // older lane's $v0 write feeds the younger SYSCALL in the same cycle
      rdy2 = 1'b1;
      c2(0, 1'b1, 32'h500, 32'h2402000a, 1'b1, 5'd2, 32'ha, 1'b1);
      c2(1, 1'b1, 32'h504, SYS, 1'b0, 5'd0, 32'h0, 1'b1);
      tick();
      chk("ord_done", 128'(dn2), 128'(1));
      idle();
      repeat (3) tick();
      chk("ord_q2", 128'(q2.size()), 128'(0));

      do_reset("r3");

      // dual-issue partial overflow and pop-frees-space
      rdy2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         c2(0, 1'b1, 32'h600 + 32'(k * 8), 32'h24080000 | 32'(k), 1'b1, 5'd8, 32'(k), 1'b1);
         c2(1, 1'b1, 32'h604 + 32'(k * 8), 32'h24090000 | 32'(k), 1'b1, 5'd9, 32'(k), 1'b1);
         tick();
      end
      chk("po_st6", 128'(st2), 128'(0));
      c2(0, 1'b1, 32'h640, 32'h240a0000, 1'b1, 5'd10, 32'h40, 1'b1);
      c2(1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      chk("po_st7", 128'(st2), 128'(1));
      c2(0, 1'b1, 32'h644, 32'h240b0000, 1'b1, 5'd11, 32'h44, 1'b1);
      c2(1, 1'b1, 32'h648, 32'h240c0000, 1'b1, 5'd12, 32'h48, 1'b0);
      tick();
      chk("po_of",  128'(of2),  128'(1));
      chk("po_cnt", 128'(cnt2), 128'(8));
      rdy2 = 1'b1;
      c2(0, 1'b1, 32'h64c, 32'h240d0000, 1'b1, 5'd13, 32'h4c, 1'b1);
      c2(1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      chk("pf_cnt", 128'(cnt2), 128'(8));
      idle();
      repeat (8) tick();
      chk("po_drain", 128'(cnt2), 128'(0));
      chk("po_st0",   128'(st2),  128'(0));

      // pointer wrap at DEPTH-1 occupancy, then async reset mid-stream
      rdy1 = 1'b0;
      rdy2 = 1'b0;
      for (int k = 0; k < 7; k++) begin
         c1(1'b1, 32'h800 + 32'(k * 4), 32'h24100000 | 32'(k), 1'b1, 5'd16, 32'(k), 1'b1);
         tick();
      end
      rdy1 = 1'b1;
      for (int k = 7; k < 31; k++) begin
         c1(1'b1, 32'h800 + 32'(k * 4), 32'h24100000 | 32'(k), 1'b1, 5'd16, 32'(k), 1'b1);
         tick();
         chk("wrap_cnt", 128'(cnt1), 128'(7));
      end
      chk("wrap_of", 128'(of1), 128'(0));
      do_reset("mid");

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
